// File: rtl/dm_trace_mem.sv
// dm_trace_mem: data memory with post-reset clear sweep and committed-store trace FIFO.
// Define DM_READ_REG_EN for a registered, write-first read port; otherwise the read is combinational.
module dm_trace_mem #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [31:0]                      m_data_addr,
    input  logic [DATA_W-1:0]                m_data_wdata,
    input  logic [DATA_W/8-1:0]              m_data_byteen,
    input  logic [31:0]                      m_inst_addr,
    output logic [DATA_W-1:0]                m_data_rdata,
    output logic                             busy,
    output logic                             err,
    output logic                             tr_valid,
    input  logic                             tr_ready,
    output logic [31:0]                      tr_pc,
    output logic [31:0]                      tr_addr,
    output logic [DATA_W-1:0]                tr_data,
    output logic [$clog2(TRACE_DEPTH):0]     tr_count,
    output logic                             tr_overflow
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFS   = $clog2(BE_W);
    localparam int PW    = $clog2(TRACE_DEPTH);
    localparam int CW    = PW + 1;
    localparam int WORDS = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic [DATA_W-1:0]   mem [WORDS];
    logic [ADDR_W-1:0]   widx;
    logic [DATA_W-1:0]   old, merged;
    logic                run, in_range, store, full, pop, push;
    logic [31:0]         f_pc   [TRACE_DEPTH];
    logic [31:0]         f_addr [TRACE_DEPTH];
    logic [DATA_W-1:0]   f_data [TRACE_DEPTH];
    logic [PW-1:0]       wp, rp;

    assign run      = state == RUN;
    assign busy     = ~run;
    assign widx     = m_data_addr[OFS+ADDR_W-1:OFS];
    assign in_range = (m_data_addr >> (OFS + ADDR_W)) == 32'd0;
    assign old      = mem[widx];
    assign store    = run & in_range & (|m_data_byteen);

    for (genvar i = 0; i < BE_W; i++) begin : g_lane
        assign merged[8*i +: 8] = m_data_byteen[i] ? m_data_wdata[8*i +: 8] : old[8*i +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CLEAR;
            idx   <= '0;
            err   <= 1'b0;
        end else begin
            if (!run) begin
                idx <= idx + 1'b1;
                if (&idx) state <= RUN;
            end
            if (run & ~in_range & (|m_data_byteen)) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!run) mem[idx] <= '0;
        else if (store) mem[widx] <= merged;
    end

`ifdef DM_READ_REG_EN
    // merged equals old when no lane is enabled, giving write-first behaviour for free
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) m_data_rdata <= '0;
        else m_data_rdata <= (run & in_range) ? merged : '0;
    end
`else
    assign m_data_rdata = (run & in_range) ? old : '0;
`endif

    assign tr_valid = tr_count != '0;
    assign full     = tr_count == CW'(TRACE_DEPTH);
    assign pop      = tr_valid & tr_ready;
    assign push     = store & (~full | pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp          <= '0;
            rp          <= '0;
            tr_count    <= '0;
            tr_overflow <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            tr_count <= tr_count + CW'(push) - CW'(pop);
            if (store & full & ~pop) tr_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_pc[wp]   <= m_inst_addr;
            f_addr[wp] <= m_data_addr & ~32'(BE_W - 1);
            f_data[wp] <= merged;
        end
    end

    assign tr_pc   = f_pc[rp];
    assign tr_addr = f_addr[rp];
    assign tr_data = f_data[rp];
endmodule

// File: tb/tb_dm_trace_mem.sv
// tb_dm_trace_mem: directed table, corner sequences and random traffic against a queue/array model.
module tb_dm_trace_mem;
    logic        clk, reset;
    logic [31:0] m_data_addr, m_data_wdata, m_inst_addr, m_data_rdata;
    logic [3:0]  m_data_byteen;
    logic        busy, err, tr_valid, tr_ready, tr_overflow;
    logic [31:0] tr_pc, tr_addr, tr_data;
    logic [3:0]  tr_count;

    dm_trace_mem #(.ADDR_W(4), .DATA_W(32), .TRACE_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr), .m_data_rdata(m_data_rdata),
        .busy(busy), .err(err), .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc),
        .tr_addr(tr_addr), .tr_data(tr_data), .tr_count(tr_count), .tr_overflow(tr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {logic [31:0] pc, addr, data;} ent_t;
    typedef struct {logic [31:0] addr, wdata; logic [3:0] be; logic [31:0] pc, exp;} vec_t;

    int          total, passed;
    logic [31:0] mmem [16];
    ent_t        q [$];
    int          sweep_left;
    logic        m_err, m_ovf;
    logic [31:0] rq;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // one clock cycle: drive, compare at negedge against the model, then advance the model at the edge
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] pc, input logic rdy);
        logic oor, bsy, pop;
        logic [31:0] mg;
        ent_t e;
        m_data_addr = a; m_data_wdata = d; m_data_byteen = be; m_inst_addr = pc; tr_ready = rdy;
        @(negedge clk);
        bsy = sweep_left > 0;
        oor = (a >> 6) != 0;
        mg  = merge(mmem[a[5:2]], d, be);
        chk("busy", busy, bsy);
        chk("err", err, m_err);
        chk("ovf", tr_overflow, m_ovf);
        chk("valid", tr_valid, q.size() > 0);
        chk("count", tr_count, q.size());
`ifdef DM_READ_REG_EN
        chk("rdata", m_data_rdata, rq);
`else
        chk("rdata", m_data_rdata, (bsy || oor) ? 32'h0 : mmem[a[5:2]]);
`endif
        if (q.size() > 0) begin
            chk("head_pc", tr_pc, q[0].pc);
            chk("head_addr", tr_addr, q[0].addr);
            chk("head_data", tr_data, q[0].data);
        end
        pop = (q.size() > 0) && rdy;
        rq = (bsy || oor) ? 32'h0 : mg;
        if (pop) void'(q.pop_front());
        if (bsy) begin
            mmem[16 - sweep_left] = 32'h0;
            sweep_left--;
        end else if (be != 0) begin
            if (oor) m_err = 1'b1;
            else begin
                mmem[a[5:2]] = mg;
                e.pc = pc; e.addr = {a[31:2], 2'b00}; e.data = mg;
                if (q.size() < 8) q.push_back(e);
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(m_data_addr, 32'h0, 4'h0, 32'h0, rdy);
    endtask

    task automatic rd_check(input logic [31:0] a, input logic [31:0] exp, input string n);
        cyc(a, 32'h0, 4'h0, 32'h0, 1'b0);
        cyc(a, 32'h0, 4'h0, 32'h0, 1'b0);
        chk(n, m_data_rdata, exp);
    endtask

    task automatic do_reset(input logic check_vals);
        reset = 1'b0;
        m_data_byteen = 4'h0;
        tr_ready = 1'b0;
        sweep_left = 16; m_err = 1'b0; m_ovf = 1'b0; rq = 32'h0;
        q.delete();
        for (int i = 0; i < 16; i++) mmem[i] = 32'h0;
        #1;
        if (check_vals) begin
            chk("rst_busy", busy, 1'b1);
            chk("rst_err", err, 1'b0);
            chk("rst_valid", tr_valid, 1'b0);
            chk("rst_count", tr_count, 4'd0);
            chk("rst_ovf", tr_overflow, 1'b0);
            chk("rst_rdata", m_data_rdata, 32'h0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic sweep_len(input string n);
        int c;
        c = 0;
        while (busy && c < 100) begin
            idle(1'b0);
            c++;
        end
        chk(n, c, 16);
    endtask

    vec_t tbl [7];

    initial begin
        total = 0; passed = 0;
        m_data_addr = 32'h0; m_data_wdata = 32'h0; m_inst_addr = 32'h0;
        tbl[0] = '{32'h8,  32'h11223344, 4'hF, 32'h3000, 32'h11223344};
        tbl[1] = '{32'h8,  32'hAABBCCDD, 4'h5, 32'h3004, 32'h11BB33DD};
        tbl[2] = '{32'h3C, 32'hCAFEF00D, 4'hF, 32'h3008, 32'hCAFEF00D};
        tbl[3] = '{32'h3C, 32'h12345678, 4'hA, 32'h300C, 32'h12FE560D};
        tbl[4] = '{32'h0,  32'hFFFFFFFF, 4'h8, 32'h3010, 32'hFF000000};
        tbl[5] = '{32'h0,  32'h000000AA, 4'h1, 32'h3014, 32'hFF0000AA};
        tbl[6] = '{32'h9,  32'h00000077, 4'h1, 32'h3018, 32'h11BB3377};

        do_reset(1'b1);
        sweep_len("sweep_len");
        rd_check(32'hC, 32'h0, "word3_clear");

        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].pc, 1'b0);
            rd_check(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
        end
        chk("head0_pc", tr_pc, 32'h3000);
        chk("head0_addr", tr_addr, 32'h8);
        chk("head0_data", tr_data, 32'h11223344);
        idle(1'b1);
        chk("head1_pc", tr_pc, 32'h3004);
        chk("head1_addr", tr_addr, 32'h8);
        chk("head1_data", tr_data, 32'h11BB33DD);
        for (int i = 0; i < 3; i++) cyc(32'h10, 32'h100 + i, 4'hF, 32'h5000 + i, 1'b0);
        chk("full_count", tr_count, 4'd8);
        chk("full_ovf", tr_overflow, 1'b1);
        chk("full_head", tr_pc, 32'h3004);
        cyc(32'h14, 32'h5A5A5A5A, 4'hF, 32'h6000, 1'b1);
        chk("pp_count", tr_count, 4'd8);
        chk("pp_head", tr_pc, 32'h3008);
        begin
            int c;
            c = 0;
            while (tr_valid && c < 20) begin
                idle(1'b1);
                c++;
            end
            chk("drained", tr_valid, 1'b0);
        end

        chk("err_before", err, 1'b0);
        cyc(32'h00010000, 32'hFFFFFFFF, 4'hF, 32'h7000, 1'b0);
        chk("oor_err", err, 1'b1);
        chk("oor_notrace", tr_count, 4'd0);
        rd_check(32'h00010000, 32'h0, "oor_read");
        cyc(32'h40, 32'hFFFFFFFF, 4'hF, 32'h7004, 1'b0);
        chk("oor40_notrace", tr_count, 4'd0);
        rd_check(32'h40, 32'h0, "oor40_read");
        rd_check(32'h3C, 32'h12FE560D, "top_intact");

        m_data_addr = 32'h4; m_data_wdata = 32'hDEADBEEF; m_data_byteen = 4'hF;
`ifdef DM_READ_REG_EN
        cyc(32'h4, 32'hDEADBEEF, 4'hF, 32'h8000, 1'b0);
        chk("write_first", m_data_rdata, 32'hDEADBEEF);
`else
        #1;
        chk("read_before_write", m_data_rdata, 32'h0);
        cyc(32'h4, 32'hDEADBEEF, 4'hF, 32'h8000, 1'b0);
        chk("after_write", m_data_rdata, 32'hDEADBEEF);
`endif

        do_reset(1'b0);
        begin
            int c;
            c = 0;
            while (busy && c < 100) begin
                if (c == 0) cyc(32'h8, 32'h55555555, 4'hF, 32'h4000, 1'b0);
                else if (c == 15) cyc(32'h0, 32'h66666666, 4'hF, 32'h4004, 1'b0);
                else idle(1'b0);
                c++;
            end
            chk("busy_sweep_len", c, 16);
        end
        chk("busy_notrace", tr_count, 4'd0);
        chk("busy_noerr", err, 1'b0);
        rd_check(32'h8, 32'h0, "busy_word2");
        rd_check(32'h0, 32'h0, "busy_word0");

        do_reset(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);
        do_reset(1'b0);
        sweep_len("midsweep_len");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom_range(0, 32'h4F);
            if ($urandom_range(0, 15) == 0) a = a | 32'h00010000;
            cyc(a, $urandom, 4'($urandom_range(0, 15)), $urandom,
                (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
